// File: rtl/des_pkg.sv
// Shared constants, permutation tables and helpers for the DES key schedule.
// The ERR state exists only when DES_KEY_PARITY_CHECK_EN is defined.
package des_pkg;

  localparam int SUBKEY_W   = 48;
  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 28;
  localparam int KEY_W      = 64;
  localparam int BUS_W      = SUBKEY_W * NUM_ROUNDS;

  // Tables use DES numbering: bit 1 is the most significant bit.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

`ifdef DES_KEY_PARITY_CHECK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DONE, ST_ERR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DONE} state_t;
`endif

  function automatic logic [55:0] pc1(input logic [KEY_W-1:0] key);
    logic [55:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) res[55-i] = key[KEY_W-PC1[i]];
    return res;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
    logic [SUBKEY_W-1:0] res;
    res = '0;
    for (int i = 0; i < SUBKEY_W; i++) res[SUBKEY_W-1-i] = cd[56-PC2[i]];
    return res;
  endfunction

  // Slot i sits at bits [767-48*(i-1) -: 48]; decrypt stores round n in slot 17-n.
  function automatic int slot_lsb(input logic [4:0] round, input logic decrypt);
    int slot;
    slot = decrypt ? (NUM_ROUNDS + 1 - int'(round)) : int'(round);
    return SUBKEY_W * (NUM_ROUNDS - slot);
  endfunction

endpackage

// File: rtl/des_subkey_step.sv
// One combinational key-schedule round: rotate C/D by the scheduled amount
// and derive the round subkey through PC-2.
module des_subkey_step
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   c_in,
  input  logic [HALF_W-1:0]   d_in,
  input  logic [4:0]          round,
  output logic [HALF_W-1:0]   c_out,
  output logic [HALF_W-1:0]   d_out,
  output logic [SUBKEY_W-1:0] subkey
);

  logic [3:0] sched_idx;
  logic       rot_two;

  // Rounds are numbered 1..16; the table index wraps harmlessly outside GEN.
  assign sched_idx = 4'(round - 5'd1);
  assign rot_two   = (SHIFTS[sched_idx] == 2);

  always_comb begin
    if (rot_two) begin
      c_out = {c_in[HALF_W-3:0], c_in[HALF_W-1:HALF_W-2]};
      d_out = {d_in[HALF_W-3:0], d_in[HALF_W-1:HALF_W-2]};
    end else begin
      c_out = {c_in[HALF_W-2:0], c_in[HALF_W-1]};
      d_out = {d_in[HALF_W-2:0], d_in[HALF_W-1]};
    end
    subkey = pc2({c_out, d_out});
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key expansion: produces all 16 subkeys, KEYS_PER_CYCLE per clock,
// in encrypt or reversed order. Optional parity check: DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int KEYS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic [KEY_W-1:0]  key_in,
  output logic [BUS_W-1:0]  round_keys,
  output logic              keys_ready,
  output logic              busy,
  output logic              key_err
);

  state_t state, next_state;

  logic [HALF_W-1:0]   c_q, d_q;
  logic [4:0]          r_q, r_next;
  logic                dec_q;
  logic [BUS_W-1:0]    round_keys_q;
  logic [55:0]         cd_init;
  logic                load, gen;

  logic [HALF_W-1:0]   c_chain [KEYS_PER_CYCLE+1];
  logic [HALF_W-1:0]   d_chain [KEYS_PER_CYCLE+1];
  logic [SUBKEY_W-1:0] subkeys [KEYS_PER_CYCLE];
  logic [4:0]          rounds  [KEYS_PER_CYCLE];

  assign cd_init    = pc1(key_in);
  assign r_next     = r_q + 5'(KEYS_PER_CYCLE);
  assign c_chain[0] = c_q;
  assign d_chain[0] = d_q;

  // Rotations chain through the steps so several rounds complete per cycle.
  for (genvar j = 0; j < KEYS_PER_CYCLE; j++) begin : g_step
    assign rounds[j] = r_q + 5'(j + 1);
    des_subkey_step u_step (
      .c_in   (c_chain[j]),
      .d_in   (d_chain[j]),
      .round  (rounds[j]),
      .c_out  (c_chain[j+1]),
      .d_out  (d_chain[j+1]),
      .subkey (subkeys[j])
    );
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_ok;

  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key_in[8*b +: 8])) parity_ok = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    gen        = 1'b0;
    case (state)
      ST_GEN: begin
        gen = 1'b1;
        if (r_next >= 5'(NUM_ROUNDS)) next_state = ST_DONE;
      end
      default: begin
        if (start) begin
`ifdef DES_KEY_PARITY_CHECK_EN
          if (parity_ok) begin
            load       = 1'b1;
            next_state = ST_GEN;
          end else begin
            next_state = ST_ERR;
          end
`else
          load       = 1'b1;
          next_state = ST_GEN;
`endif
        end
      end
    endcase
  end

  // round_keys is deliberately kept on load so a consumer of the old set
  // is not disturbed until the new set overwrites each slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q          <= '0;
      d_q          <= '0;
      r_q          <= '0;
      dec_q        <= 1'b0;
      round_keys_q <= '0;
    end else if (load) begin
      c_q   <= cd_init[55:28];
      d_q   <= cd_init[27:0];
      r_q   <= '0;
      dec_q <= decrypt;
    end else if (gen) begin
      c_q <= c_chain[KEYS_PER_CYCLE];
      d_q <= d_chain[KEYS_PER_CYCLE];
      r_q <= r_next;
      for (int j = 0; j < KEYS_PER_CYCLE; j++) begin
        round_keys_q[slot_lsb(rounds[j], dec_q) +: SUBKEY_W] <= subkeys[j];
      end
    end
  end

  assign round_keys = round_keys_q;
  assign busy       = (state == ST_GEN);
  assign keys_ready = (state == ST_DONE);
`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_err    = (state == ST_ERR);
`else
  assign key_err    = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: one instance at 1 key/cycle and
// one at 4 keys/cycle, checked against a bit-level DES key-schedule model.
module tb_des_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, start4, decrypt;
  logic [63:0]  key_in;
  logic [767:0] rk1, rk4;
  logic         ready1, ready4, busy1, busy4, err1, err4;

  int checks = 0;
  int errors = 0;

  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  always #5 clk = ~clk;

  des_key_schedule #(.KEYS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .round_keys(rk1), .keys_ready(ready1), .busy(busy1), .key_err(err1)
  );

  des_key_schedule #(.KEYS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .decrypt(decrypt), .key_in(key_in),
    .round_keys(rk4), .keys_ready(ready4), .busy(busy4), .key_err(err4)
  );

  // Reference: C/D after round n are the PC-1 halves rotated by the running shift total.
  function automatic logic [767:0] model(input logic [63:0] key, input bit dec);
    logic [767:0] res;
    bit kb [1:64];
    bit c0 [1:28];
    bit d0 [1:28];
    bit cd [1:56];
    int tot, slot;
    res = '0;
    for (int b = 1; b <= 64; b++) kb[b] = key[64-b];
    for (int i = 1; i <= 28; i++) begin
      c0[i] = kb[pc1_t[i-1]];
      d0[i] = kb[pc1_t[27+i]];
    end
    tot = 0;
    for (int n = 1; n <= 16; n++) begin
      tot += shift_t[n-1];
      for (int i = 1; i <= 28; i++) begin
        cd[i]    = c0[((i - 1 + tot) % 28) + 1];
        cd[28+i] = d0[((i - 1 + tot) % 28) + 1];
      end
      slot = dec ? 17 - n : n;
      for (int m = 1; m <= 48; m++) res[767 - 48*(slot-1) - (m-1)] = cd[pc2_t[m-1]];
    end
    return res;
  endfunction

  function automatic logic [47:0] slot_of(input logic [767:0] bus, input int i);
    return bus[767 - 48*(i-1) -: 48];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic s4, input logic dec, input logic [63:0] k);
    start   = s;
    start4  = s4;
    decrypt = dec;
    key_in  = k;
  endtask

  task automatic checkOutput(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after the capture edge; scrambles key_in/decrypt every cycle of GEN
  // and optionally pulses start (with key 0) at cycle inject_at.
  task automatic waitReady(input int inject_at, output int cnt1, output int cnt4, output int busy_cnt);
    cnt1 = -1;
    cnt4 = -1;
    busy_cnt = busy1 ? 1 : 0;
    applyStimulus(1'b0, 1'b0, 1'($urandom), {$urandom, $urandom});
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready4 && cnt4 < 0) cnt4 = i;
      if (ready1) begin
        cnt1 = i;
        break;
      end
      if (busy1) busy_cnt++;
      if (i == inject_at) applyStimulus(1'b1, 1'b0, 1'($urandom), 64'h0);
      else                applyStimulus(1'b0, 1'b0, 1'($urandom), {$urandom, $urandom});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    int c1, c4, bc;
    logic [767:0] exp, held;
    logic [63:0] rkey;
    bit rdec;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_round_keys", rk1, '0);
    checkOutput("reset_keys_ready", {767'b0, ready1}, '0);
    checkOutput("reset_busy", {767'b0, busy1}, '0);
    checkOutput("reset_key_err", {767'b0, err1}, '0);

    // Encrypt ordering, both widths started together.
    applyStimulus(1'b1, 1'b1, 1'b0, KEY_A);
    tick();
    checkOutput("enc_busy_after_start", {767'b0, busy1}, 768'd1);
    waitReady(0, c1, c4, bc);
    exp = model(KEY_A, 1'b0);
    checkOutput("enc_latency_k1", 768'(c1), 768'd16);
    checkOutput("enc_latency_k4", 768'(c4), 768'd4);
    checkOutput("enc_busy_cycles", 768'(bc), 768'd16);
    checkOutput("enc_slot1", {720'b0, slot_of(rk1, 1)}, {720'b0, 48'h1B02EFFC7072});
    checkOutput("enc_slot16", {720'b0, slot_of(rk1, 16)}, {720'b0, 48'hCB3D8B0E17F5});
    checkOutput("enc_bus_k1", rk1, exp);
    checkOutput("enc_bus_k4", rk4, exp);

    repeat (3) tick();
    checkOutput("done_hold_bus", rk1, exp);
    checkOutput("done_hold_ready", {767'b0, ready1}, 768'd1);

    // Decrypt ordering; the accepted start drops keys_ready at its edge.
    applyStimulus(1'b1, 1'b1, 1'b1, KEY_A);
    tick();
    checkOutput("dec_ready_drop", {767'b0, ready1}, '0);
    waitReady(0, c1, c4, bc);
    exp = model(KEY_A, 1'b1);
    checkOutput("dec_latency_k1", 768'(c1), 768'd16);
    checkOutput("dec_slot1", {720'b0, slot_of(rk1, 1)}, {720'b0, 48'hCB3D8B0E17F5});
    checkOutput("dec_slot16", {720'b0, slot_of(rk1, 16)}, {720'b0, 48'h1B02EFFC7072});
    checkOutput("dec_bus_k1", rk1, exp);
    checkOutput("dec_bus_k4", rk4, exp);

    // Random keys with a start pulse (key 0) injected mid-GEN on the 1/cycle instance.
    for (int t = 0; t < 4; t++) begin
      rkey = {$urandom, $urandom};
      rdec = 1'($urandom);
      applyStimulus(1'b1, 1'b1, rdec, rkey);
      tick();
      waitReady(5, c1, c4, bc);
      exp = model(rkey, rdec);
      checkOutput($sformatf("rand%0d_latency", t), 768'(c1), 768'd16);
      checkOutput($sformatf("rand%0d_bus_k1", t), rk1, exp);
      checkOutput($sformatf("rand%0d_bus_k4", t), rk4, exp);
    end

    // Parity handling on a start from DONE with a nonzero result held.
    held = rk1;
    applyStimulus(1'b1, 1'b0, 1'b0, KEY_BAD);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
`ifdef DES_KEY_PARITY_CHECK_EN
    checkOutput("parity_key_err", {767'b0, err1}, 768'd1);
    checkOutput("parity_ready_low", {767'b0, ready1}, '0);
    checkOutput("parity_busy_low", {767'b0, busy1}, '0);
    checkOutput("parity_bus_kept", rk1, held);
    tick();
    checkOutput("parity_err_held", {767'b0, err1}, 768'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, KEY_A);
    tick();
    checkOutput("parity_err_cleared", {767'b0, err1}, '0);
    checkOutput("parity_restart_busy", {767'b0, busy1}, 768'd1);
    waitReady(0, c1, c4, bc);
    checkOutput("parity_restart_bus", rk1, model(KEY_A, 1'b0));
`else
    checkOutput("noparity_key_err", {767'b0, err1}, '0);
    checkOutput("noparity_busy", {767'b0, busy1}, 768'd1);
    waitReady(0, c1, c4, bc);
    checkOutput("noparity_bits_ignored", rk1, model(KEY_A, 1'b0));
`endif

    // Reset during GEN cycle 7 wipes everything.
    applyStimulus(1'b1, 1'b1, 1'b0, KEY_A);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, KEY_A);
    repeat (6) tick();
    checkOutput("midgen_busy", {767'b0, busy1}, 768'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midgen_rst_bus", rk1, '0);
    checkOutput("midgen_rst_busy", {767'b0, busy1}, '0);
    checkOutput("midgen_rst_ready", {767'b0, ready1}, '0);
    checkOutput("midgen_rst_bus_k4", rk4, '0);

    // Back-to-back: start with key 0 while DONE.
    applyStimulus(1'b1, 1'b0, 1'b0, KEY_A);
    tick();
    waitReady(0, c1, c4, bc);
    checkOutput("b2b_first_bus", rk1, model(KEY_A, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("b2b_ready_drop", {767'b0, ready1}, '0);
    waitReady(0, c1, c4, bc);
    checkOutput("b2b_latency", 768'(c1), 768'd16);
    checkOutput("b2b_zero_bus", rk1, model(64'h0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
